xor_frame_loader: RTL and testbench

- Upstream feeder for the XOR encryption top level: accepts one parallel key/message pair per valid/ready handshake.
- Serializes the pair onto the shared single-bit data line (key first, then message) with the matching load strobes and enable.
- Holds the frame busy until the downstream done flag finishes, so a new frame cannot corrupt an encryption in flight.
- Bit timing is expressed in fast-clock cycles, so the loader shares the system clock with the downstream clock divider.

---
 rtl/xor_pkg.sv | 21 ++
 rtl/xor_frame_loader_bit_timer.sv | 41 ++++
 rtl/xor_frame_loader.sv | 194 +++++++++++++++++++
 tb/tb_xor_frame_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/xor_pkg.sv
// Shared definitions for the XOR encryption datapath: loader state encoding and
// the default frame geometry used by the loader, deserializer, assembler and serializer.
package xor_pkg;

    localparam int XOR_KEY_SIZE   = 4;
    localparam int XOR_MSG_SIZE   = 8;
    localparam int XOR_BIT_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY       = 3'd1,
        GAP       = 3'd2,
        MSG       = 3'd3,
        WAIT_DONE = 3'd4
    } loader_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/xor_frame_loader_bit_timer.sv
// Bit-period timer: counts BIT_CYCLES fast-clock cycles per serial bit and flags the
// last cycle of each period; held at zero while reload_i is high.
module bit_timer
    import xor_pkg::*;
#(
    parameter int BIT_CYCLES = XOR_BIT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic reload_i,
    output logic bit_tick_o
);

    localparam int CNT_W = $clog2(BIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick_o = (cnt_q == LAST_CNT);

    // Next count: restart outside the serial states and wrap at each bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (reload_i || bit_tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/xor_frame_loader.sv
// Frame loader: accepts a key/message pair, serializes key then message onto the
// shared data line with load strobes, then waits for the downstream done flag.
module xor_frame_loader
    import xor_pkg::*;
#(
    parameter int KEY_SIZE     = XOR_KEY_SIZE,
    parameter int MSG_SIZE     = XOR_MSG_SIZE,
    parameter int BIT_CYCLES   = XOR_BIT_CYCLES,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iValid,
    input  logic [KEY_SIZE-1:0] iKey,
    input  logic [MSG_SIZE-1:0] iMsg,
    output logic                oReady,
    output logic                oEn,
    output logic                oData,
    output logic                oLoad_key,
    output logic                oLoad_msg,
    input  logic                iDone_flag,
    output logic                oFrame_done,
    output logic                oError
);

    localparam int IDX_W = $clog2(max_int(KEY_SIZE, MSG_SIZE) + 1);
    localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(KEY_SIZE - 1);
    localparam logic [IDX_W-1:0] MSG_LAST = IDX_W'(MSG_SIZE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(DONE_TIMEOUT);

    loader_state_e       state_q, state_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [MSG_SIZE-1:0] msg_q, msg_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                seen_q, seen_d;
    logic                done_q;
    logic                ready_q, ready_d;
    logic                en_q, en_d;
    logic                data_q, data_d;
    logic                lk_q, lk_d;
    logic                lm_q, lm_d;
    logic                fd_q, fd_d;
    logic                err_q, err_d;
    logic                bit_tick_s;
    logic                reload_s;
    logic                done_fall_s;
    logic                timeout_s;

    assign reload_s    = !((state_q == KEY) || (state_q == GAP) || (state_q == MSG));
    assign done_fall_s = seen_q && done_q && !iDone_flag;
    assign timeout_s   = (tmo_q == TMO_LAST);

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk_i     (iClk),
        .rst_ni    (iRst),
        .reload_i  (reload_s),
        .bit_tick_o(bit_tick_s)
    );

    // Next-state, shift/counter updates and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        msg_d   = msg_q;
        idx_d   = idx_q;
        tmo_d   = '0;
        seen_d  = 1'b0;
        fd_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (iValid && ready_q) begin
                    key_d   = iKey;
                    msg_d   = iMsg;
                    idx_d   = '0;
                    state_d = KEY;
                end else begin
                    state_d = IDLE;
                end
            end
            KEY: begin
                if (bit_tick_s) begin
                    key_d = key_q << 1'b1;
                    if (idx_q == KEY_LAST) begin
                        idx_d   = '0;
                        state_d = GAP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = KEY;
                end
            end
            GAP: begin
                if (bit_tick_s) begin
                    state_d = MSG;
                end else begin
                    state_d = GAP;
                end
            end
            MSG: begin
                if (bit_tick_s) begin
                    msg_d = msg_q << 1'b1;
                    if (idx_q == MSG_LAST) begin
                        idx_d   = '0;
                        state_d = WAIT_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = MSG;
                end
            end
            WAIT_DONE: begin
                // A completed high-then-low done cycle takes priority over the timeout.
                seen_d = seen_q | iDone_flag;
                tmo_d  = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
                if (done_fall_s) begin
                    fd_d    = 1'b1;
                    state_d = IDLE;
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        en_d    = (state_d != IDLE);
        lk_d    = (state_d == KEY);
        lm_d    = (state_d == MSG);
        if (state_d == KEY) begin
            data_d = key_d[KEY_SIZE-1];
        end else if (state_d == MSG) begin
            data_d = msg_d[MSG_SIZE-1];
        end else begin
            data_d = 1'b0;
        end
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q <= IDLE;
            key_q   <= '0;
            msg_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            seen_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            en_q    <= 1'b0;
            data_q  <= 1'b0;
            lk_q    <= 1'b0;
            lm_q    <= 1'b0;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            msg_q   <= msg_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            seen_q  <= seen_d;
            done_q  <= iDone_flag;
            ready_q <= ready_d;
            en_q    <= en_d;
            data_q  <= data_d;
            lk_q    <= lk_d;
            lm_q    <= lm_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
        end
    end

    assign oReady      = ready_q;
    assign oEn         = en_q;
    assign oData       = data_q;
    assign oLoad_key   = lk_q;
    assign oLoad_msg   = lm_q;
    assign oFrame_done = fd_q;
    assign oError      = err_q;

endmodule

// File: tb/tb_xor_frame_loader.sv
// Self-checking bench for xor_frame_loader: two instances (BIT_CYCLES 2 and 1, DONE_TIMEOUT 20)
// compared cycle by cycle against an expected trace derived from the frame rules.
module tb_xor_frame_loader;

    localparam int KS = 4;
    localparam int MS = 8;
    localparam int TO = 20;
    localparam logic [6:0] IDLE_V = 7'b1000000;

    logic          iClk = 1'b0;
    logic          iRst = 1'b0;
    logic          v0 = 1'b0, v1 = 1'b0, dn0 = 1'b0, dn1 = 1'b0;
    logic [KS-1:0] k0 = '0, k1 = '0;
    logic [MS-1:0] m0 = '0, m1 = '0;
    logic          r0, en0, d0, lk0, lm0, fd0, er0;
    logic          r1, en1, d1, lk1, lm1, fd1, er1;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    always #5 iClk = ~iClk;

    xor_frame_loader #(.KEY_SIZE(KS), .MSG_SIZE(MS), .BIT_CYCLES(2), .DONE_TIMEOUT(TO)) dut0 (
        .iClk(iClk), .iRst(iRst), .iValid(v0), .iKey(k0), .iMsg(m0), .oReady(r0),
        .oEn(en0), .oData(d0), .oLoad_key(lk0), .oLoad_msg(lm0), .iDone_flag(dn0),
        .oFrame_done(fd0), .oError(er0));

    xor_frame_loader #(.KEY_SIZE(KS), .MSG_SIZE(MS), .BIT_CYCLES(1), .DONE_TIMEOUT(TO)) dut1 (
        .iClk(iClk), .iRst(iRst), .iValid(v1), .iKey(k1), .iMsg(m1), .oReady(r1),
        .oEn(en1), .oData(d1), .oLoad_key(lk1), .oLoad_msg(lm1), .iDone_flag(dn1),
        .oFrame_done(fd1), .oError(er1));

    typedef struct {
        int          sel;
        logic [3:0]  key;
        logic [7:0]  msg;
        bit          bp;
        int          d;
        int          h;
        int          exp_w;
        bit          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (rdy,en,data,lk,lm,fdone,err) at %0t",
                     name, act, exp_v, $time);
        end
    endtask

    function automatic logic [6:0] obs(input int sel);
        if (sel == 1) return {r1, en1, d1, lk1, lm1, fd1, er1};
        return {r0, en0, d0, lk0, lm0, fd0, er0};
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic [3:0] k,
                            input logic [7:0] m, input logic dn);
        if (sel == 1) begin
            v1 = v; k1 = k; m1 = m; dn1 = dn;
        end else begin
            v0 = v; k0 = k; m0 = m; dn0 = dn;
        end
    endtask

    // Reference rule: done completes the cycle after the first low sample following a high
    // stretch; otherwise the timeout fires TO cycles into the wait; a tie goes to done.
    function automatic int pulse_w(input int d, input int h, output bit is_err);
        if (h > 0 && d + h + 1 <= TO) begin
            is_err = 1'b0;
            return d + h + 1;
        end
        is_err = 1'b1;
        return TO;
    endfunction

    task automatic drive_filler(input int sel, input bit bp, input logic dn);
        if (bp) drive_in(sel, 1'b1, 4'($urandom), 8'($urandom), dn);
        else    drive_in(sel, 1'b0, 4'h0, 8'h00, dn);
    endtask

    // Handshake one frame, check every serial cycle, then the wait phase up to its pulse.
    task automatic run_frame(input int sel, input logic [3:0] key, input logic [7:0] msg,
                             input bit bp, input int d, input int h, input int exp_w,
                             input bit exp_err, input string tag);
        int bc;
        int b;
        logic [6:0] exp_v;
        logic dn;
        bc = (sel == 1) ? 1 : 2;
        drive_in(sel, 1'b1, key, msg, 1'b0);
        step();
        for (int j = 0; j < (KS + MS + 1) * bc; j++) begin
            b = j / bc;
            drive_filler(sel, bp, 1'b0);
            if (b < KS)       exp_v = {1'b0, 1'b1, key[KS-1-b], 1'b1, 1'b0, 2'b00};
            else if (b == KS) exp_v = 7'b0100000;
            else              exp_v = {1'b0, 1'b1, msg[MS-1-(b-KS-1)], 1'b0, 1'b1, 2'b00};
            check({tag, "_serial"}, obs(sel), exp_v);
            step();
        end
        for (int w = 0; w <= exp_w; w++) begin
            dn = (h > 0) && (w >= d) && (w < d + h);
            if (w < exp_w) begin
                check({tag, "_wait"}, obs(sel), 7'b0100000);
                drive_filler(sel, bp, dn);
                step();
            end else begin
                exp_v = {1'b1, 5'b00000, 1'b0};
                exp_v[1] = !exp_err;
                exp_v[0] = exp_err;
                check({tag, "_pulse"}, obs(sel), exp_v);
                drive_filler(sel, bp, 1'b0);
            end
        end
    endtask

    // Strobes must never overlap on either instance.
    always @(negedge iClk) begin
        if (mon_en) check("no_overlap", {5'b00000, lk0 & lm0, lk1 & lm1}, 7'b0000000);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 4'hB, 8'hA5, 1'b0, 0, 16, 17, 1'b0};
        vecs[1] = '{0, 4'h6, 8'h3C, 1'b0, 0, 0, 20, 1'b1};
        vecs[2] = '{0, 4'h9, 8'h81, 1'b0, 2, 17, 20, 1'b0};
        vecs[3] = '{0, 4'h0, 8'hFF, 1'b0, 5, 15, 20, 1'b1};
        vecs[4] = '{1, 4'hF, 8'h00, 1'b0, 1, 2, 4, 1'b0};
        vecs[5] = '{0, 4'h5, 8'h5A, 1'b1, 3, 4, 8, 1'b0};
        vecs[6] = '{0, 4'hA, 8'hC3, 1'b0, 0, 1, 2, 1'b0};

        iRst = 1'b0;
        step();
        step();
        check("reset_dut0", obs(0), IDLE_V);
        check("reset_dut1", obs(1), IDLE_V);
        iRst = 1'b1;
        mon_en = 1'b1;
        step();
        check("idle_dut0", obs(0), IDLE_V);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].sel, vecs[i].key, vecs[i].msg, vecs[i].bp, vecs[i].d,
                      vecs[i].h, vecs[i].exp_w, vecs[i].exp_err, "table");
            if (!vecs[i].bp) begin
                step();
                check("table_idle", obs(vecs[i].sel), IDLE_V);
            end
        end

        // Reset during the third message bit aborts the frame without a pulse.
        drive_in(0, 1'b1, 4'hB, 8'hA5, 1'b0);
        step();
        drive_in(0, 1'b0, 4'h0, 8'h00, 1'b0);
        for (int j = 0; j < (KS + 1 + 2) * 2; j++) step();
        check("mid_msg_strobe", obs(0), {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00});
        iRst = 1'b0;
        step();
        iRst = 1'b1;
        check("mid_reset", obs(0), IDLE_V);
        for (int j = 0; j < 3; j++) begin
            step();
            check("post_reset_idle", obs(0), IDLE_V);
        end
        run_frame(0, 4'h3, 8'h96, 1'b0, 0, 2, 3, 1'b0, "post_reset");
        step();
        check("post_reset_end", obs(0), IDLE_V);

        for (int r = 0; r < 12; r++) begin
            int sel, d, h, w;
            bit er;
            sel = (r % 3 == 2) ? 1 : 0;
            d = int'($urandom_range(0, 12));
            h = int'($urandom_range(0, 12));
            w = pulse_w(d, h, er);
            run_frame(sel, 4'($urandom), 8'($urandom), 1'b0, d, h, w, er, "rand");
            step();
            check("rand_idle", obs(sel), IDLE_V);
        end

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
